// File: rtl/pipe_stage_buf.sv
// Flow-controlled inter-stage pipeline register with optional skid entry,
// synchronous flush, occupancy reporting and a saturating back-pressure counter.
module pipe_stage_buf #(
    parameter int CTRL_W = 7,
    parameter int DATA_W = 128,
    parameter int SKID   = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              flush_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [CTRL_W-1:0] ctrl_o,
    output logic [DATA_W-1:0] data_o,
    output logic [1:0]        occ_o,
    output logic [CNT_W-1:0]  bp_cnt_o
);

    // State encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t state_q;
    state_t state_d;

    logic [CTRL_W-1:0] m_ctrl_q;
    logic [DATA_W-1:0] m_data_q;
    logic [CTRL_W-1:0] s_ctrl_q;
    logic [DATA_W-1:0] s_data_q;
    logic [CNT_W-1:0]  bp_cnt_q;

    logic in_xfer;
    logic out_xfer;
    logic m_load_in;
    logic m_load_skid;
    logic s_load;

    assign in_xfer  = valid_i & ready_o;
    assign out_xfer = valid_o & ready_i;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        m_load_in   = 1'b0;
        m_load_skid = 1'b0;
        s_load      = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_xfer) begin
                    state_d   = ONE;
                    m_load_in = 1'b1;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    m_load_in = 1'b1;
                end else if (in_xfer && (SKID != 0)) begin
                    state_d = FULL;
                    s_load  = 1'b1;
                end else if (out_xfer) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    state_d     = ONE;
                    m_load_skid = 1'b1;
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
        // Flush drops held and incoming entries but leaves payload registers alone.
        if (flush_i) begin
            state_d     = EMPTY;
            m_load_in   = 1'b0;
            m_load_skid = 1'b0;
            s_load      = 1'b0;
        end
    end

    always_comb begin
        valid_o = (state_q != EMPTY);
        occ_o   = state_q;
        data_o  = m_data_q;
        ctrl_o  = valid_o ? m_ctrl_q : '0;
        if (SKID != 0) begin
            ready_o = (state_q != FULL);
        end else begin
            ready_o = (state_q == EMPTY) | ready_i;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            m_ctrl_q <= '0;
            m_data_q <= '0;
            s_ctrl_q <= '0;
            s_data_q <= '0;
        end else begin
            if (m_load_in) begin
                m_ctrl_q <= ctrl_i;
                m_data_q <= data_i;
            end else if (m_load_skid) begin
                m_ctrl_q <= s_ctrl_q;
                m_data_q <= s_data_q;
            end
            if (s_load) begin
                s_ctrl_q <= ctrl_i;
                s_data_q <= data_i;
            end
            if (flush_i) begin
                m_ctrl_q <= '0;
                s_ctrl_q <= '0;
            end
        end
    end

    // Counts stalled cycles regardless of flush; only reset clears it.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            bp_cnt_q <= '0;
        end else if (valid_o && !ready_i && (bp_cnt_q != {CNT_W{1'b1}})) begin
            bp_cnt_q <= bp_cnt_q + 1'b1;
        end
    end

    assign bp_cnt_o = bp_cnt_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench: skid instance (CNT_W=4) and single-register instance share stimulus.
module tb_pipe_stage_buf;

    logic         clock_i = 1'b0;
    logic         reset_i = 1'b0;
    logic         flush_i = 1'b0;
    logic         valid_i = 1'b0;
    logic         ready_i = 1'b0;
    logic [6:0]   ctrl_i  = '0;
    logic [127:0] data_i  = '0;

    logic         a_ready, a_valid, b_ready, b_valid;
    logic [6:0]   a_ctrl, b_ctrl;
    logic [127:0] a_data, b_data;
    logic [1:0]   a_occ, b_occ;
    logic [3:0]   a_bp;
    logic [15:0]  b_bp;

    int checks   = 0;
    int failures = 0;

    always #5 clock_i = ~clock_i;

    pipe_stage_buf #(.CTRL_W(7), .DATA_W(128), .SKID(1), .CNT_W(4)) dut_a (
        .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(a_ready), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(a_valid), .ready_i(ready_i), .ctrl_o(a_ctrl), .data_o(a_data),
        .occ_o(a_occ), .bp_cnt_o(a_bp)
    );

    pipe_stage_buf #(.CTRL_W(7), .DATA_W(128), .SKID(0), .CNT_W(16)) dut_b (
        .clock_i(clock_i), .reset_i(reset_i), .flush_i(flush_i),
        .valid_i(valid_i), .ready_o(b_ready), .ctrl_i(ctrl_i), .data_i(data_i),
        .valid_o(b_valid), .ready_i(ready_i), .ctrl_o(b_ctrl), .data_o(b_data),
        .occ_o(b_occ), .bp_cnt_o(b_bp)
    );

    task automatic checkOutput(input string tag, input logic [127:0] actual,
                               input logic [127:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic flush, input logic valid, input logic ready,
                                 input logic [6:0] ctrl, input logic [127:0] data);
        flush_i = flush;
        valid_i = valid;
        ready_i = ready;
        ctrl_i  = ctrl;
        data_i  = data;
    endtask

    initial begin
        // Async reset asserted mid-cycle
        #2 reset_i = 1'b1;
        #1;
        checkOutput("rst_valid", a_valid, 0);
        checkOutput("rst_ctrl", a_ctrl, 0);
        checkOutput("rst_data", a_data, 0);
        checkOutput("rst_occ", a_occ, 0);
        checkOutput("rst_ready", a_ready, 1);
        checkOutput("rst_bp", a_bp, 0);
        @(negedge clock_i);
        reset_i = 1'b0;

        // Streaming
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(0, 1, 1, 7'h55, 128'(k));
            if (k == 1) begin
                #1 checkOutput("stream_lat", a_valid, 0);
            end
            @(negedge clock_i);
            checkOutput($sformatf("stream_data%0d", k), a_data, 128'(k));
            checkOutput("stream_valid", a_valid, 1);
            checkOutput("stream_ctrl", a_ctrl, 7'h55);
            checkOutput("stream_occ", a_occ, 1);
            checkOutput("stream_ready", a_ready, 1);
        end
        applyStimulus(0, 0, 1, 0, 0);
        @(negedge clock_i);
        checkOutput("drain_valid", a_valid, 0);
        checkOutput("drain_ctrl", a_ctrl, 0);
        checkOutput("drain_bp", a_bp, 0);

        // Skid fill
        applyStimulus(0, 1, 0, 7'h11, 128'hA);
        @(negedge clock_i);
        checkOutput("skid_occ1", a_occ, 1);
        applyStimulus(0, 1, 0, 7'h22, 128'hB);
        @(negedge clock_i);
        checkOutput("skid_occ2", a_occ, 2);
        checkOutput("skid_ready", a_ready, 0);
        checkOutput("skid_ctrl", a_ctrl, 7'h11);
        checkOutput("skid_dataA", a_data, 128'hA);
        checkOutput("skid_bp", a_bp, 1);
        applyStimulus(0, 0, 1, 0, 0);
        @(negedge clock_i);
        checkOutput("skid_occ_b", a_occ, 1);
        checkOutput("skid_dataB", a_data, 128'hB);
        checkOutput("skid_ctrlB", a_ctrl, 7'h22);
        @(negedge clock_i);
        checkOutput("skid_occ_0", a_occ, 0);
        checkOutput("skid_valid_0", a_valid, 0);

        // Flush priority from FULL with a simultaneous incoming entry
        applyStimulus(0, 1, 0, 7'h33, 128'hD);
        @(negedge clock_i);
        applyStimulus(0, 1, 0, 7'h44, 128'hE);
        @(negedge clock_i);
        checkOutput("fl_full", a_occ, 2);
        applyStimulus(1, 1, 0, 7'h66, 128'hC);
        @(negedge clock_i);
        checkOutput("fl_occ", a_occ, 0);
        checkOutput("fl_valid", a_valid, 0);
        checkOutput("fl_ctrl", a_ctrl, 0);
        checkOutput("fl_ready", a_ready, 1);
        checkOutput("fl_data_kept", a_data, 128'hD);
        checkOutput("fl_bp", a_bp, 3);
        applyStimulus(0, 0, 1, 0, 0);
        @(negedge clock_i);
        checkOutput("fl_noC", a_valid, 0);

        // Back-pressure saturation at 15
        applyStimulus(0, 1, 0, 7'h0F, 128'hF);
        @(negedge clock_i);
        applyStimulus(0, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) @(negedge clock_i);
        checkOutput("bp_sat", a_bp, 15);
        checkOutput("bp_occ", a_occ, 1);
        applyStimulus(1, 0, 0, 0, 0);
        @(negedge clock_i);
        checkOutput("bp_flush", a_bp, 15);
        checkOutput("bp_flush_occ", a_occ, 0);

        // Async reset while FULL
        applyStimulus(0, 1, 0, 7'h01, 128'h100);
        @(negedge clock_i);
        applyStimulus(0, 1, 0, 7'h02, 128'h200);
        @(negedge clock_i);
        checkOutput("ar_full", a_occ, 2);
        applyStimulus(0, 0, 0, 0, 0);
        #2 reset_i = 1'b1;
        #1;
        checkOutput("ar_valid", a_valid, 0);
        checkOutput("ar_ctrl", a_ctrl, 0);
        checkOutput("ar_occ", a_occ, 0);
        checkOutput("ar_ready", a_ready, 1);
        checkOutput("ar_bp", a_bp, 0);
        @(negedge clock_i);
        reset_i = 1'b0;

        // SKID=0: combinational ready
        applyStimulus(0, 0, 0, 0, 0);
        #1 checkOutput("b_ready_empty", b_ready, 1);
        applyStimulus(0, 1, 1, 7'h12, 128'hE1);
        @(negedge clock_i);
        checkOutput("b_occ1", b_occ, 1);
        checkOutput("b_data1", b_data, 128'hE1);
        applyStimulus(0, 0, 1, 0, 0);
        #1 checkOutput("b_ready_hi", b_ready, 1);
        applyStimulus(0, 0, 0, 0, 0);
        #1 checkOutput("b_ready_lo", b_ready, 0);
        applyStimulus(0, 1, 0, 7'h13, 128'hE2);
        #1 checkOutput("b_ready_lo2", b_ready, 0);
        @(negedge clock_i);
        checkOutput("b_occ_hold", b_occ, 1);
        checkOutput("b_data_hold", b_data, 128'hE1);
        applyStimulus(0, 1, 1, 7'h13, 128'hE2);
        #1 checkOutput("b_ready_pass", b_ready, 1);
        @(negedge clock_i);
        checkOutput("b_occ_pass", b_occ, 1);
        checkOutput("b_data_pass", b_data, 128'hE2);
        checkOutput("b_ctrl_pass", b_ctrl, 7'h13);
        applyStimulus(0, 0, 1, 0, 0);
        @(negedge clock_i);
        checkOutput("b_occ_0", b_occ, 0);
        checkOutput("b_ctrl_0", b_ctrl, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
